// File: rtl/alu_arb_pkg.sv
// Shared types for the two-port shared-ALU arbiter: FSM states, owner id and ALU op codes.
// No logic here; latency and backpressure are properties of the modules that import it.
package alu_arb_pkg;

    localparam int OP_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic owner_t;

    localparam owner_t PORT0 = 1'b0;
    localparam owner_t PORT1 = 1'b1;

    localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB    = 5'b00001;
    localparam logic [OP_W-1:0] OP_PASS_B = 5'b01111;
    localparam logic [OP_W-1:0] OP_CLZ    = 5'b10001;

    // Tie winner given the previous owner: the port that did not go last.
    function automatic owner_t rr_pick(input owner_t last_owner);
        return (last_owner == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port opposite last_i.
// Purely combinational, zero latency; no backpressure of its own (caller gates the grant).
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic       gnt_vld_o,
    output owner_t     gnt_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_o     = PORT0;
        case (req_i)
            2'b01:   gnt_o = PORT0;
            2'b10:   gnt_o = PORT1;
            2'b11:   gnt_o = rr_pick(last_i);
            default: gnt_o = PORT0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters, one transaction in flight.
// Latency: accept at edge t, response valid from cycle t+2; issue interval >= 3 cycles.
// Backpressure: result held until owner's rsp_ready; ALU_ARB_FIXED_PRIO_EN gives port 0 every tie.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OP_W-1:0] req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OP_W-1:0] req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OP_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0] alu_result,

    output logic            busy
);

    state_e          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;

    logic   gnt_vld;
    owner_t gnt_owner;
    owner_t arb_last;
    logic   grant_en;
    logic   req_hs;
    logic   own_rsp_ready;

    rr_arb2 u_arb (
        .req_i     ({req1_valid, req0_valid}),
        .last_i    (arb_last),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt_owner)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Constant "last = port 1" makes every tie resolve to port 0.
    assign arb_last = PORT1;
`else
    owner_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (req_hs) begin
            last_d = gnt_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign arb_last = last_q;
`endif

    // Ready is a function of state and request side only, never of the response side.
    assign grant_en   = (state_q == IDLE) && !rst;
    assign req0_ready = grant_en && gnt_vld && (gnt_owner == PORT0);
    assign req1_ready = grant_en && gnt_vld && (gnt_owner == PORT1);
    assign req_hs     = grant_en && gnt_vld;

    assign own_rsp_ready = (owner_q == PORT1) ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_d = EXEC;
                    owner_d = gnt_owner;
                    if (gnt_owner == PORT1) begin
                        op_d = req1_op;
                        a_d  = req1_a;
                        b_d  = req1_b;
                    end else begin
                        op_d = req0_op;
                        a_d  = req0_a;
                        b_d  = req0_b;
                    end
                end
            end
            EXEC: begin
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                if (own_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= PORT0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // The ALU sees only latched operands, so they persist through IDLE and RESP.
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;

    assign rsp0_valid  = (state_q == RESP) && (owner_q == PORT0);
    assign rsp1_valid  = (state_q == RESP) && (owner_q == PORT1);
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU stub plus directed scenarios and a random transaction-level model.
module tb_alu_share_arb;
    import alu_arb_pkg::*;

    localparam int XLEN = 32;

    logic            clk, rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OP_W-1:0] req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp0_result, rsp1_result;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0] alu_ctrl;
    logic            busy;

    int   total = 0;
    int   bad   = 0;
    logic m_last;

    alu_share_arb #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [XLEN-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        int n;
        logic found;
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_PASS_B: return b;
            OP_CLZ: begin
                n = 0;
                found = 1'b0;
                for (int i = XLEN - 1; i >= 0; i--) begin
                    if (!found && a[i]) found = 1'b1;
                    if (!found) n++;
                end
                return XLEN'(n);
            end
            default:   return a ^ b;
        endcase
    endfunction

    // External ALU stand-in.
    always_comb alu_result = ref_alu(alu_ctrl, alu_a, alu_b);

    function automatic int tie_winner(input logic last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return last ? 0 : 1;
`endif
    endfunction

    function automatic logic [OP_W-1:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return OP_ADD;
            1:       return OP_SUB;
            2:       return OP_PASS_B;
            3:       return OP_CLZ;
            default: return OP_W'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1; rsp1_ready = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        req0_valid = 1;
        req1_valid = 1;
        tick();
        tick();
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
        end
        total++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b000 || alu_a !== '0 || alu_b !== '0 ||
            alu_ctrl !== '0 || rsp0_result !== '0 || rsp1_result !== '0) begin
            bad++;
            $display("FAIL reset_values busy=%b v0=%b v1=%b a=%h b=%h ctrl=%h r0=%h r1=%h exp all zero",
                     busy, rsp0_valid, rsp1_valid, alu_a, alu_b, alu_ctrl, rsp0_result, rsp1_result);
        end
        req0_valid = 0;
        req1_valid = 0;
        rst = 0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy=%b exp=0", busy);
        end
        m_last = 1'b1;
    endtask

    task automatic test_single();
        req0_op = OP_ADD; req0_a = 5; req0_b = 7; req0_valid = 1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        req0_a = 99;
        #1;
        total++;
        if ({busy, rsp0_valid, req0_ready} !== 3'b100 || alu_a !== 5 || alu_b !== 7 || alu_ctrl !== OP_ADD) begin
            bad++;
            $display("FAIL single_exec busy=%b v0=%b rdy=%b a=%0d b=%0d ctrl=%h exp busy=1 v0=0 rdy=0 a=5 b=7 ctrl=0",
                     busy, rsp0_valid, req0_ready, alu_a, alu_b, alu_ctrl);
        end
        tick();
        total++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b110 || rsp0_result !== 12) begin
            bad++;
            $display("FAIL single_resp busy=%b v0=%b v1=%b res=%0d exp busy=1 v0=1 v1=0 res=12",
                     busy, rsp0_valid, rsp1_valid, rsp0_result);
        end
        tick();
        total++;
        if ({busy, rsp0_valid} !== 2'b00 || alu_a !== 5) begin
            bad++; $display("FAIL single_done busy=%b v0=%b alu_a=%0d exp 0 0 5", busy, rsp0_valid, alu_a);
        end
        m_last = 1'b0;
    endtask

    task automatic test_tie();
        bit seen0, seen1, overlap, a0, a1;
        int first;
        logic [XLEN-1:0] r0, r1;
        rst = 1;
        tick();
        rst = 0;
        m_last = 1'b1;
        seen0 = 0; seen1 = 0; overlap = 0; first = -1; r0 = '0; r1 = '0;
        req0_op = OP_SUB;    req0_a = 10; req0_b = 3;          req0_valid = 1;
        req1_op = OP_PASS_B; req1_a = 0;  req1_b = 32'hABCD;   req1_valid = 1;
        #1;
        for (int k = 0; k < 30 && !(seen0 && seen1); k++) begin
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (rsp1_valid && !seen0) overlap = 1;
            if (rsp0_valid && !seen0) begin seen0 = 1; r0 = rsp0_result; if (first < 0) first = 0; end
            if (rsp1_valid && !seen1) begin seen1 = 1; r1 = rsp1_result; if (first < 0) first = 1; end
            tick();
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
            #1;
        end
        total++;
        if (!(seen0 && seen1)) begin
            bad++; $display("FAIL tie_timeout seen0=%0d seen1=%0d exp both", seen0, seen1);
        end
        total++;
        if (first != 0) begin
            bad++; $display("FAIL tie_order first=%0d exp=0", first);
        end
        total++;
        if (r0 !== 7) begin
            bad++; $display("FAIL tie_res0 got=%h exp=7", r0);
        end
        total++;
        if (r1 !== 32'hABCD) begin
            bad++; $display("FAIL tie_res1 got=%h exp=abcd", r1);
        end
        total++;
        if (overlap) begin
            bad++; $display("FAIL tie_rsp1_early got=1 exp=0");
        end
        tick();
        m_last = 1'b1;
    endtask

    task automatic test_rr_rounds();
        bit found;
        int g, expg;
        logic [XLEN-1:0] exp;
        clear_inputs();
        req0_op = pick_op(); req0_a = $urandom; req0_b = $urandom;
        req1_op = pick_op(); req1_a = $urandom; req1_b = $urandom;
        req0_valid = 1;
        req1_valid = 1;
        #1;
        for (int r = 0; r < 4; r++) begin
            found = 0;
            for (int k = 0; k < 10; k++) begin
                if (req0_ready || req1_ready) begin found = 1; break; end
                tick();
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL rr_grant_timeout round=%0d", r);
            end else begin
                g = req1_ready ? 1 : 0;
                expg = tie_winner(m_last);
                total++;
                if (g != expg) begin
                    bad++; $display("FAIL rr_grant round=%0d got=%0d exp=%0d", r, g, expg);
                end
                exp = (g == 1) ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
                m_last = (g == 1);
                tick();
                req0_op = pick_op(); req0_a = $urandom; req0_b = $urandom;
                req1_op = pick_op(); req1_a = $urandom; req1_b = $urandom;
                #1;
                found = 0;
                for (int k = 0; k < 6; k++) begin
                    if ((g == 0 && rsp0_valid) || (g == 1 && rsp1_valid)) begin found = 1; break; end
                    tick();
                end
                total++;
                if (!found || ((g == 0) ? rsp0_result : rsp1_result) !== exp) begin
                    bad++;
                    $display("FAIL rr_result round=%0d found=%0d got=%h exp=%h", r, found,
                             (g == 0) ? rsp0_result : rsp1_result, exp);
                end
                tick();
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        #1;
        tick();
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] exp;
        bit ok;
        clear_inputs();
        rsp0_ready = 0;
        req0_op = OP_ADD; req0_a = $urandom; req0_b = $urandom; req0_valid = 1;
        exp = req0_a + req0_b;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL bp_accept rdy=%b exp=1", req0_ready);
        end
        tick();
        m_last = 1'b0;
        req0_a = ~req0_a;
        req1_valid = 1;
        tick();
        tick();
        ok = 1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy} !== 5'b10001 || rsp0_result !== exp) begin
                bad++; ok = 0;
                $display("FAIL bp_hold cyc=%0d v0=%b v1=%b r0=%b r1=%b busy=%b res=%h exp 1 0 0 0 1 res=%h",
                         k, rsp0_valid, rsp1_valid, req0_ready, req1_ready, busy, rsp0_result, exp);
            end
            tick();
        end
        req0_valid = 0;
        req1_valid = 0;
        rsp0_ready = 1;
        #1;
        tick();
        total++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            bad++; $display("FAIL bp_release busy=%b v0=%b exp 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_reset_exec();
        bit stale;
        clear_inputs();
        req0_op = OP_ADD; req0_a = 1; req0_b = 2; req0_valid = 1;
        #1;
        tick();
        req0_valid = 0;
        #1;
        total++;
        if (busy !== 1'b1 || alu_a !== 1) begin
            bad++; $display("FAIL rst_exec_pre busy=%b alu_a=%0d exp 1 1", busy, alu_a);
        end
        rst = 1;
        req0_valid = 1;
        tick();
        total++;
        if ({busy, rsp0_valid, rsp1_valid, req0_ready} !== 4'b0000 || alu_a !== '0 || alu_b !== '0 ||
            alu_ctrl !== '0 || rsp0_result !== '0) begin
            bad++;
            $display("FAIL rst_exec_vals busy=%b v0=%b v1=%b rdy=%b a=%h b=%h ctrl=%h res=%h exp all zero",
                     busy, rsp0_valid, rsp1_valid, req0_ready, alu_a, alu_b, alu_ctrl, rsp0_result);
        end
        req0_valid = 0;
        rst = 0;
        stale = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp0_valid || rsp1_valid || busy) stale = 1;
        end
        total++;
        if (stale) begin
            bad++; $display("FAIL rst_exec_stale got=1 exp=0");
        end
        m_last = 1'b1;
    endtask

    task automatic test_operand_change();
        bit found;
        clear_inputs();
        req0_op = OP_CLZ; req0_a = 32'h0001_0000; req0_b = 0; req0_valid = 1;
        #1;
        tick();
        req0_a = 0;
        req0_valid = 0;
        #1;
        total++;
        if (alu_a !== 32'h0001_0000 || alu_ctrl !== OP_CLZ) begin
            bad++; $display("FAIL opchg_latch alu_a=%h ctrl=%h exp 00010000 11", alu_a, alu_ctrl);
        end
        found = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp0_valid) begin found = 1; break; end
            tick();
        end
        total++;
        if (!found || rsp0_result !== 15) begin
            bad++; $display("FAIL opchg_result found=%0d got=%0d exp=15", found, rsp0_result);
        end
        tick();
        m_last = 1'b0;
    endtask

    // Transaction-level model: one job pending, response visible from two cycles after accept.
    task automatic test_random();
        bit pend;
        int age, owner, w;
        logic [XLEN-1:0] mexp;
        logic [4:0] expv, gotv;
        logic er0, er1, ev0, ev1;
        pend = 0; age = 0; owner = 0; mexp = '0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = pick_op(); req0_a = $urandom; req0_b = $urandom;
            req1_op = pick_op(); req1_a = $urandom; req1_b = $urandom;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (req0_valid && req1_valid) w = tie_winner(m_last);
            else w = req1_valid ? 1 : 0;
            er0 = !pend && req0_valid && (w == 0);
            er1 = !pend && req1_valid && (w == 1);
            ev0 = pend && age >= 2 && owner == 0;
            ev1 = pend && age >= 2 && owner == 1;
            expv = {er1, er0, ev1, ev0, pend};
            gotv = {req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy};
            total++;
            if (gotv !== expv) begin
                bad++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", c, gotv, expv);
            end
            if (ev0 || ev1) begin
                total++;
                if ((ev1 ? rsp1_result : rsp0_result) !== mexp) begin
                    bad++; $display("FAIL rnd_res cyc=%0d got=%h exp=%h", c, ev1 ? rsp1_result : rsp0_result, mexp);
                end
            end
            if (pend) begin
                if (age >= 2 && ((owner == 1) ? rsp1_ready : rsp0_ready)) pend = 0;
                else age++;
            end else if (er0 || er1) begin
                pend = 1;
                age = 1;
                owner = w;
                mexp = (w == 1) ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
                m_last = (w == 1);
            end
            tick();
        end
        clear_inputs();
        #1;
        for (int k = 0; k < 6; k++) tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        m_last = 1'b1;
        test_reset();
        test_single();
        test_tie();
        test_rr_rounds();
        test_backpressure();
        test_reset_exec();
        test_operand_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
